// File: rtl/qspi_pkg.sv
// qspi_pkg: FSM states, opcodes and field lengths for the QPI flash controller.
// The QSPI_WRITE_EN macro adds the page-program (write) path.
package qspi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DUMMY,
    DATA,
    END
  } state_t;

  localparam logic [7:0] CMD_RD = 8'hEB;
`ifdef QSPI_WRITE_EN
  localparam logic [7:0] CMD_WR = 8'h38;
`endif

  localparam logic [3:0] CMD_NIB  = 4'd2;
  localparam logic [3:0] ADDR_NIB = 4'd6;
  localparam logic [3:0] DATA_NIB = 4'd2;

endpackage

// File: rtl/qspi_ctrl.sv
// qspi_ctrl: single-byte QPI (4-4-4) flash access, SCK = CLK/2, mode 0.
// Define QSPI_WRITE_EN for writes; otherwise write requests ack at once.
module qspi_ctrl
  import qspi_pkg::*;
#(
  parameter int DUMMY_CYCLES = 6
) (
  input  logic        CLK,
  input  logic        RES_N,
  input  logic        BUS_REQ,
  input  logic        BUS_WE,
  input  logic [23:0] BUS_ADDR,
  input  logic [7:0]  BUS_WDATA,
  output logic [7:0]  BUS_RDATA,
  output logic        BUS_ACK,
  output logic        QSPI_CS_N,
  output logic        QSPI_CS_E,
  output logic        QSPI_SCK,
  output logic        QSPI_SCK_E,
  output logic [3:0]  QSPI_SIO_O,
  output logic [3:0]  QSPI_SIO_E,
  input  logic [3:0]  QSPI_SIO_I
);

  localparam bit         HAS_DUMMY = (DUMMY_CYCLES > 0);
  localparam logic [3:0] DUM_LAST  = 4'(DUMMY_CYCLES - 1);

  state_t      state_q;
  state_t      state_d;
  state_t      start_st;
  logic        armed_q;
  logic        ph_q;
  logic [3:0]  nib_q;
  logic [3:0]  nib_last;
  logic [31:0] sr_q;
  logic [7:0]  rdata_q;
  logic [7:0]  cmd_sel;
  logic        we_q;
  logic        busy;
  logic        accept;
  logic        fld_end;
  logic        rd_smp;

  assign busy    = (state_q == CMD) || (state_q == ADDR) ||
                   (state_q == DUMMY) || (state_q == DATA);
  assign accept  = (state_q == IDLE) && BUS_REQ && armed_q;
  assign fld_end = ph_q && (nib_q == nib_last);
  assign rd_smp  = (state_q == DATA) && !we_q;

`ifdef QSPI_WRITE_EN
  logic [7:0] wdata_q;

  assign start_st = CMD;
  assign cmd_sel  = BUS_WE ? CMD_WR : CMD_RD;

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
    end else if (accept) begin
      we_q    <= BUS_WE;
      wdata_q <= BUS_WDATA;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^BUS_WDATA;
  assign we_q         = 1'b0;
  assign start_st     = BUS_WE ? END : CMD;
  assign cmd_sel      = CMD_RD;
`endif

  always_comb begin
    nib_last = 4'd0;
    unique case (state_q)
      CMD:     nib_last = CMD_NIB - 4'd1;
      ADDR:    nib_last = ADDR_NIB - 4'd1;
      DUMMY:   nib_last = DUM_LAST;
      DATA:    nib_last = DATA_NIB - 4'd1;
      default: nib_last = 4'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = start_st;
      CMD:   if (fld_end) state_d = ADDR;
      ADDR:
        if (fld_end)
          state_d = (!we_q && HAS_DUMMY) ? DUMMY : DATA;
      DUMMY: if (fld_end) state_d = DATA;
      DATA:  if (fld_end) state_d = END;
      END:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Nibbles advance at the end of the SCK-high phase, which is also
  // where read data is sampled.
  always_ff @(posedge CLK or negedge RES_N) begin
    if (!RES_N) begin
      armed_q <= 1'b0;
      ph_q    <= 1'b0;
      nib_q   <= 4'd0;
      sr_q    <= 32'h0;
      rdata_q <= 8'h00;
    end else begin
      armed_q <= 1'b1;
      if (!busy) begin
        ph_q  <= 1'b0;
        nib_q <= 4'd0;
        if (accept) sr_q <= {cmd_sel, BUS_ADDR};
      end else begin
        ph_q <= ~ph_q;
        if (ph_q) begin
          nib_q <= fld_end ? 4'd0 : nib_q + 4'd1;
          sr_q  <= {sr_q[27:0], rd_smp ? QSPI_SIO_I : 4'h0};
          if (rd_smp && fld_end)
            rdata_q <= {sr_q[3:0], QSPI_SIO_I};
`ifdef QSPI_WRITE_EN
          if ((state_q == ADDR) && fld_end && we_q)
            sr_q <= {wdata_q, 24'h0};
`endif
        end
      end
    end
  end

  assign QSPI_CS_N  = !busy;
  assign QSPI_CS_E  = 1'b1;
  assign QSPI_SCK   = busy && ph_q;
  assign QSPI_SCK_E = 1'b1;
  assign QSPI_SIO_E = ((state_q == CMD) || (state_q == ADDR) ||
                       ((state_q == DATA) && we_q)) ? 4'hF : 4'h0;
  assign QSPI_SIO_O = (QSPI_SIO_E != 4'h0) ? sr_q[31:28] : 4'h0;
  assign BUS_ACK    = (state_q == END);
  assign BUS_RDATA  = rdata_q;

endmodule

// File: tb/tb_qspi_ctrl.sv
// tb_qspi_ctrl: directed checks of qspi_ctrl with a small QPI device model.
// Write expectations follow the QSPI_WRITE_EN build option.
module tb_qspi_ctrl;

  localparam int DUM = 6;

  logic        CLK = 1'b0;
  logic        RES_N = 1'b0;
  logic        BUS_REQ = 1'b0;
  logic        req0 = 1'b0;
  logic        BUS_WE = 1'b0;
  logic [23:0] BUS_ADDR = 24'h0;
  logic [7:0]  BUS_WDATA = 8'h0;
  logic [7:0]  BUS_RDATA;
  logic        BUS_ACK;
  logic        QSPI_CS_N, QSPI_CS_E, QSPI_SCK, QSPI_SCK_E;
  logic [3:0]  QSPI_SIO_O, QSPI_SIO_E;
  logic [3:0]  sio_i = 4'h0;

  logic [7:0]  d0_rdata;
  logic        d0_ack, d0_cs_n, d0_cs_e, d0_sck, d0_sck_e;
  logic [3:0]  d0_sio_o, d0_sio_e;

  int          n_chk = 0;
  int          n_err = 0;
  int          sck_bad = 0;
  int          sck_n = 0;
  logic [7:0]  dev_byte = 8'hA5;
  logic [3:0]  nib_o[$];
  logic [3:0]  nib_e[$];

  always #5 CLK = ~CLK;

  qspi_ctrl #(.DUMMY_CYCLES(DUM)) u_dut (
    .CLK(CLK), .RES_N(RES_N),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .QSPI_CS_N(QSPI_CS_N), .QSPI_CS_E(QSPI_CS_E),
    .QSPI_SCK(QSPI_SCK), .QSPI_SCK_E(QSPI_SCK_E),
    .QSPI_SIO_O(QSPI_SIO_O), .QSPI_SIO_E(QSPI_SIO_E),
    .QSPI_SIO_I(sio_i)
  );

  qspi_ctrl #(.DUMMY_CYCLES(0)) u_dut0 (
    .CLK(CLK), .RES_N(RES_N),
    .BUS_REQ(req0), .BUS_WE(BUS_WE),
    .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(d0_rdata), .BUS_ACK(d0_ack),
    .QSPI_CS_N(d0_cs_n), .QSPI_CS_E(d0_cs_e),
    .QSPI_SCK(d0_sck), .QSPI_SCK_E(d0_sck_e),
    .QSPI_SIO_O(d0_sio_o), .QSPI_SIO_E(d0_sio_e),
    .QSPI_SIO_I(4'h9)
  );

  // Device model: looks at the bus mid-cycle, logs each SCK-high nibble
  // and presents read data half a nibble before the controller samples.
  always @(negedge CLK) begin
    if (QSPI_CS_N && QSPI_SCK) sck_bad++;
    if (QSPI_CS_N) begin
      sck_n = 0;
    end else if (QSPI_SCK) begin
      nib_o.push_back(QSPI_SIO_O);
      nib_e.push_back(QSPI_SIO_E);
      sio_i = (sck_n == 8 + DUM) ? dev_byte[7:4] : dev_byte[3:0];
      sck_n++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [23:0] a,
                         input logic [7:0] wd, output int ack_at,
                         output int low_cnt);
    ack_at  = -1;
    low_cnt = 0;
    BUS_WE = we; BUS_ADDR = a; BUS_WDATA = wd; BUS_REQ = 1'b1;
    for (int n = 1; n <= 100 && ack_at < 0; n++) begin
      @(posedge CLK); #1;
      if (n == 1) begin
        BUS_WE = ~we; BUS_ADDR = ~a; BUS_WDATA = ~wd;
      end
      if (!QSPI_CS_N) low_cnt++;
      if (BUS_ACK) begin
        ack_at  = n;
        BUS_REQ = 1'b0;
      end
    end
    BUS_REQ = 1'b0;
    @(posedge CLK); #1;
  endtask

  initial begin
    int ack_at, low, base, cnt, acks, ack2, gap, ph;
    logic [39:0] pk;

    #12;
    chk("rst_cs_n", QSPI_CS_N, 1'b1);
    chk("rst_cs_e", QSPI_CS_E, 1'b1);
    chk("rst_sck", QSPI_SCK, 1'b0);
    chk("rst_sck_e", QSPI_SCK_E, 1'b1);
    chk("rst_sio_o", QSPI_SIO_O, 4'h0);
    chk("rst_sio_e", QSPI_SIO_E, 4'h0);
    chk("rst_ack", BUS_ACK, 1'b0);
    chk("rst_rdata", BUS_RDATA, 8'h00);
    @(posedge CLK); #1;
    RES_N = 1'b1;
    repeat (2) @(posedge CLK);
    #1;

    // Read 0x123456, device returns 0xA5
    dev_byte = 8'hA5;
    base = nib_o.size();
    run_req(1'b0, 24'h123456, 8'h00, ack_at, low);
    chk("rd_ack_at", ack_at, 33);
    chk("rd_cs_low", low, 32);
    chk("rd_nibs", nib_o.size() - base, 16);
    pk = '0;
    cnt = 0;
    for (int i = 0; i < 8 && base + i < nib_o.size(); i++) begin
      pk = {pk[35:0], nib_o[base + i]};
      if (nib_e[base + i] == 4'hF) cnt++;
    end
    chk("rd_hdr", pk[31:0], 32'hEB123456);
    chk("rd_oe_hdr", cnt, 8);
    cnt = 0;
    for (int i = 8; i < 16 && base + i < nib_o.size(); i++)
      if (nib_e[base + i] == 4'h0) cnt++;
    chk("rd_oe_tail", cnt, 8);
    chk("rd_rdata", BUS_RDATA, 8'hA5);

    // Write 0x3C to 0x00FF01
    base = nib_o.size();
    run_req(1'b1, 24'h00FF01, 8'h3C, ack_at, low);
`ifdef QSPI_WRITE_EN
    chk("wr_ack_at", ack_at, 21);
    chk("wr_cs_low", low, 20);
    chk("wr_nibs", nib_o.size() - base, 10);
    pk = '0;
    cnt = 0;
    for (int i = 0; i < 10 && base + i < nib_o.size(); i++) begin
      pk = {pk[35:0], nib_o[base + i]};
      if (nib_e[base + i] == 4'hF) cnt++;
    end
    chk("wr_nib_seq", pk, 40'h3800FF013C);
    chk("wr_oe", cnt, 10);
`else
    chk("wr_ack_at", ack_at, 1);
    chk("wr_cs_low", low, 0);
    chk("wr_nibs", nib_o.size() - base, 0);
`endif
    chk("wr_rdata_kept", BUS_RDATA, 8'hA5);

    // Back-to-back reads with BUS_REQ held high
    dev_byte = 8'h5A;
    BUS_WE = 1'b0; BUS_ADDR = 24'h000010; BUS_REQ = 1'b1;
    acks = 0; ack2 = -1; gap = 0; ph = 0;
    for (int n = 1; n <= 200 && acks < 2; n++) begin
      @(posedge CLK); #1;
      if (BUS_ACK) begin
        acks++;
        if (acks == 2) ack2 = n;
      end
      case (ph)
        0: if (!QSPI_CS_N) ph = 1;
        1: if (QSPI_CS_N) begin ph = 2; gap = 1; end
        2: if (QSPI_CS_N) gap++; else ph = 3;
        default: ;
      endcase
    end
    BUS_REQ = 1'b0;
    @(posedge CLK); #1;
    chk("b2b_acks", acks, 2);
    chk("b2b_gap", gap, 2);
    chk("b2b_ack2_at", ack2, 67);
    chk("b2b_rdata", BUS_RDATA, 8'h5A);

    // Reset at cycle 10 of a read
    dev_byte = 8'hA5;
    BUS_WE = 1'b0; BUS_ADDR = 24'h123456; BUS_REQ = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("pre_rst_oe", QSPI_SIO_E, 4'hF);
    #1 RES_N = 1'b0;
    #1;
    chk("arst_cs_n", QSPI_CS_N, 1'b1);
    chk("arst_sio_e", QSPI_SIO_E, 4'h0);
    chk("arst_rdata", BUS_RDATA, 8'h00);
    BUS_REQ = 1'b0;
    @(posedge CLK); #1;
    RES_N = 1'b1;
    acks = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge CLK); #1;
      if (BUS_ACK) acks++;
    end
    chk("arst_no_ack", acks, 0);
    run_req(1'b0, 24'h123456, 8'h00, ack_at, low);
    chk("arst_rd_ack_at", ack_at, 33);
    chk("arst_rd_rdata", BUS_RDATA, 8'hA5);

    // No dummy phase: DUMMY_CYCLES=0 instance
    BUS_WE = 1'b0; BUS_ADDR = 24'h000000; req0 = 1'b1;
    ack_at = -1; low = 0;
    for (int n = 1; n <= 100 && ack_at < 0; n++) begin
      @(posedge CLK); #1;
      if (!d0_cs_n) low++;
      if (d0_ack) begin ack_at = n; req0 = 1'b0; end
    end
    req0 = 1'b0;
    chk("d0_ack_at", ack_at, 21);
    chk("d0_cs_low", low, 20);
    chk("d0_rdata", d0_rdata, 8'h99);

    chk("sck_idle_low", sck_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/qspi_ctrl.md
QSPI_CTRL -- requirements
Module: qspi_ctrl

Interface
REQ-001 SHALL have parameter DUMMY_CYCLES, default 6: SCK cycles between address and read data (range 0..15).
REQ-002 SHALL have port CLK  input  1  system clock, the only clock.
REQ-003 SHALL have port RES_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port BUS_REQ  input  1  access request, held high until BUS_ACK.
REQ-005 SHALL have port BUS_WE  input  1  1=write, 0=read; valid while BUS_REQ.
REQ-006 SHALL have port BUS_ADDR  input  24  byte address.
REQ-007 SHALL have port BUS_WDATA  input  8  write byte.
REQ-008 SHALL have port BUS_RDATA  output  8  read byte, valid with BUS_ACK and held until next read completes.
REQ-009 SHALL have port BUS_ACK  output  1  one-CLK completion pulse.
REQ-010 SHALL have ports QSPI_CS_N, QSPI_CS_E, QSPI_SCK, QSPI_SCK_E  output  1 each  pad value/enable.
REQ-011 SHALL have ports QSPI_SIO_O, QSPI_SIO_E  output  4 each; QSPI_SIO_I  input  4.

Function
REQ-012 SHALL drive the device in QPI mode 0: SCK idle low, every field 4 bits per SCK, high nibble first.
REQ-013 SHALL produce SCK = CLK/2; each nibble = 2 CLK (SCK low phase, then SCK high phase).
REQ-014 SHALL change SIO_O only at the start of a SCK-low phase; SHALL sample SIO_I at the end of a SCK-high phase.
REQ-015 SHALL have FSM states IDLE, CMD, ADDR, DUMMY, DATA, END.
- IDLE->CMD on BUS_REQ.
- CMD->ADDR after 2 nibbles.
- ADDR->DUMMY (read, DUMMY_CYCLES>0) or ADDR->DATA after 6 nibbles.
- DUMMY->DATA after DUMMY_CYCLES nibbles.
- DATA->END after 2 nibbles.
- END->IDLE after 1 CLK.
REQ-016 SHALL send command 0xEB for reads and 0x38 for writes, followed by BUS_ADDR[23:0].
REQ-017 SHALL latch BUS_WE, BUS_ADDR and BUS_WDATA in the acceptance cycle; later input changes SHALL be ignored.
REQ-018 SHALL drive QSPI_SIO_E=4'hF in CMD, ADDR and write DATA, and 4'h0 in DUMMY, read DATA, END and IDLE.
REQ-019 SHALL hold QSPI_CS_N low from the CLK after acceptance for exactly 2*(8+DUMMY_CYCLES+2) CLK on reads and 20 CLK on writes.
REQ-020 SHALL pulse BUS_ACK in the END cycle: cycle 1+2*(10+DUMMY_CYCLES) after acceptance for reads (33 at default), cycle 21 for writes.
REQ-021 SHALL keep QSPI_CS_N high for at least 2 CLK between transactions, including when BUS_REQ stays high across BUS_ACK.
REQ-022 SHALL update BUS_RDATA only on read completion.
REQ-023 SHALL hold QSPI_SCK low whenever QSPI_CS_N is high.

Reset
REQ-024 SHALL, while RES_N is low, immediately force: state IDLE, QSPI_CS_N=1, QSPI_CS_E=1, QSPI_SCK=0, QSPI_SCK_E=1, QSPI_SIO_O=0, QSPI_SIO_E=0, BUS_ACK=0, BUS_RDATA=0.
REQ-025 SHALL, on reset during a transaction, abort it with no BUS_ACK.
REQ-026 SHALL accept a new request no earlier than the second CLK after RES_N deasserts.

Configuration
REQ-027 SHALL, with QSPI_WRITE_EN defined, implement writes as in REQ-016..REQ-020.
REQ-028 SHALL, without QSPI_WRITE_EN:
- acknowledge a write request one CLK after acceptance;
- produce no CS_N, SCK or SIO activity;
- leave BUS_RDATA unchanged;
- remove 0x38 and the write-data path from the logic.

Structure
REQ-029 SHALL take from package qspi_pkg: the state enum, the command constants (0xEB, 0x38) and the field nibble counts (CMD=2, ADDR=6, DATA=2).
REQ-030 SHALL be a single module with no sub-module; one nibble counter and one 32-bit shift register serve all states.

Verification
REQ-031 Read: BUS_ADDR=0x123456, DUMMY_CYCLES=6, model returns 0xA5 -> SIO_O nibbles E,B,1,2,3,4,5,6; SIO_E=0 for 8 nibbles; BUS_RDATA=0xA5; BUS_ACK at cycle 33.
REQ-032 Write (QSPI_WRITE_EN): BUS_ADDR=0x00FF01, BUS_WDATA=0x3C -> nibbles 3,8,0,0,F,F,0,1,3,C; CS_N low 20 CLK; BUS_ACK at cycle 21.
REQ-033 Back-to-back: BUS_REQ held high for two reads -> CS_N high exactly 2 CLK between them; two BUS_ACK pulses.
REQ-034 RES_N pulsed low at cycle 10 of a read -> CS_N=1 and SIO_E=0 immediately; no BUS_ACK; next read completes normally.
REQ-035 Without QSPI_WRITE_EN, write request -> BUS_ACK at cycle 1; CS_N stays high throughout.
REQ-036 DUMMY_CYCLES=0 read of 0x000000 -> no DUMMY state; BUS_ACK at cycle 21.
